sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Serial-in, parallel-out frame receiver. It recovers a WIDTH-bit word from a framed single-wire serial stream and presents it as a registered parallel word with a one-cycle valid strobe. It sits at the far end of a serial link, feeding the parallel register stage (`d`/`q`) of the datapath. Framing uses one start bit (0), WIDTH data bits, an optional parity bit, and one stop bit (1). There is one bit per clock and no oversampling.

## Interface
- `WIDTH`, default 4: data bits per frame, ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first data bit received lands in `q[WIDTH-1]`; 0 means it lands in `q[0]`.

- `clk`  input  1  rising-edge clock; one serial bit is sampled per edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sin`  input  1  serial line; idles high.
- `q`  output  WIDTH  last correctly framed word.
- `q_valid`  output  1  one-cycle strobe; `q` updated this cycle.
- `frame_err`  output  1  one-cycle strobe; stop bit was 0.
- `parity_err`  output  1  one-cycle strobe; parity mismatch (constant 0 unless `SIPO_PARITY_EN`).

## Operation
- The state machine has four states: IDLE, DATA, PAR, STOP.
- **IDLE**
  - `sin`=1: stay in IDLE.
  - `sin`=0: this edge samples the start bit. Go to DATA, clear the shift register, bit counter = 0.
- **DATA**
  - Each edge shifts `sin` into the shift register and increments the counter.
  - With `MSB_FIRST`=1 the register shifts left and `sin` enters at bit 0. With `MSB_FIRST`=0 it shifts right and `sin` enters at bit WIDTH-1.
  - On the edge where counter = WIDTH-1 (the last data bit), go to PAR if `SIPO_PARITY_EN` is defined, otherwise to STOP.
  - The counter is $clog2(WIDTH) bits wide and never wraps within a frame.
- **PAR**
  - Sample the parity bit. Even parity: XOR of the data bits and the parity bit must be 0.
  - Latch the mismatch internally and go to STOP.
- **STOP**
  - Sample the stop bit, then always return to IDLE.
  - `sin`=1 and no parity mismatch: load `q` from the shift register and assert `q_valid`.
  - `sin`=1 with a parity mismatch: assert `parity_err`; `q` is unchanged.
  - `sin`=0: assert `frame_err`; `q` is unchanged. `parity_err` is also asserted if there was a mismatch.
  - A 0 stop bit is never reinterpreted as a start bit. The line must be sampled by IDLE before the next frame starts.
- Back-to-back frames are supported: a start bit on the edge immediately after the STOP edge is accepted.
- All outputs are registered. Strobes are high for exactly one cycle.

## Timing
- **Reset values:** `q`=0, `q_valid`=0, `frame_err`=0, `parity_err`=0, state=IDLE, shift register=0, counter=0.
- **Reset mid-frame:** the frame is abandoned and no strobe is issued. Receive resumes at IDLE on the first edge after `rst` deasserts.
- **Frame length:** WIDTH+2 cycles, or WIDTH+3 with parity.
- **Latency:** the start bit is sampled at edge E0. `q`/`q_valid` update at edge E0+WIDTH+1 (E0+WIDTH+2 with parity), i.e. they are visible from the stop-bit sample edge until the next edge.
- **Minimum spacing:** with frames back to back, at most one `q_valid` per WIDTH+2 (or WIDTH+3) cycles.
- `sin` is synchronous to `clk` and must be stable around the rising edge; no synchronizer is built in.

## Configuration
- `SIPO_PARITY_EN`
  - **Defined:** the PAR state exists; frames carry an even-parity bit between the last data bit and the stop bit; `parity_err` is live.
  - **Undefined:** there is no PAR state; frames are WIDTH+2 bits; `parity_err` is tied to 0; the parity logic is absent.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Deassert, hold `sin`=1 for 20 cycles → no strobes.
- **Basic frame:** WIDTH=4, `MSB_FIRST`=1, no parity. Drive `sin` = 0,1,1,0,1,1 → `q`=4'b1101 with `q_valid` high for one cycle on the 6th edge.
- **Bit order:** `MSB_FIRST`=0, same stream → `q`=4'b1011.
- **Framing error:** drive 0,1,0,1,0 followed by stop=0 → `frame_err` pulses once; `q` keeps its previous value (4'b1101).
- **Back-to-back:** send frames 4'b1101 and 4'b0010 with no idle gap → two `q_valid` pulses 6 cycles apart with the correct values. Then assert `rst` at the 3rd data bit of a third frame → no strobe, and the next frame is received cleanly.
- **Parity:** with `SIPO_PARITY_EN`, send 1101 with parity bit 1 → `q_valid`. Send 1101 with parity bit 0 → `parity_err` pulse, no `q_valid`, `q` unchanged.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in, parallel-out frame receiver.
//
// Recovers a WIDTH-bit word from a framed single-wire stream, one bit per clk:
// start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
// Delivers the word as a registered parallel value with one-cycle strobes.
//
// Parameters:
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: first data bit lands in q[WIDTH-1]; 0: lands in q[0]
//
// Ports:
//   clk         rising-edge clock, one serial bit sampled per edge
//   rst         asynchronous active-high reset
//   sin         serial line, idles high
//   q           last correctly framed word
//   q_valid     one-cycle strobe, q updated this cycle
//   frame_err   one-cycle strobe, stop bit sampled as 0
//   parity_err  one-cycle strobe, parity mismatch (0 unless SIPO_PARITY_EN)
//
// Build option:
//   SIPO_PARITY_EN  when defined, frames carry an even-parity bit between the
//                   last data bit and the stop bit, and parity_err is live.

module sipo_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] q_n;
    logic             q_valid_n, frame_err_n, parity_err_n;
    logic             last_bit;
    logic             par_bad;

`ifdef SIPO_PARITY_EN
    logic             par_bad_n;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (!sin) state_n = DATA;
            DATA: begin
                if (last_bit) begin
`ifdef SIPO_PARITY_EN
                    state_n = PAR;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            PAR:  state_n = STOP;
`endif
            // A 0 stop bit still returns to IDLE; IDLE must see the next start.
            STOP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output / datapath logic (next values of the registered outputs)
    // ---------------------------------------------------------------
    always_comb begin
        shreg_n      = shreg;
        cnt_n        = cnt;
        q_n          = q;
        q_valid_n    = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
`ifdef SIPO_PARITY_EN
        par_bad_n    = par_bad;
`endif
        case (state)
            IDLE: begin
                if (!sin) begin
                    shreg_n = '0;
                    cnt_n   = '0;
`ifdef SIPO_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                end
            end
            DATA: begin
                if (MSB_FIRST) shreg_n = {shreg[WIDTH-2:0], sin};
                else           shreg_n = {sin, shreg[WIDTH-1:1]};
                // Hold on the last bit so the counter never wraps mid-frame.
                if (!last_bit) cnt_n = cnt + CW'(1);
            end
`ifdef SIPO_PARITY_EN
            PAR: par_bad_n = (^shreg) ^ sin;
`endif
            STOP: begin
                if (sin) begin
                    if (par_bad) begin
                        parity_err_n = 1'b1;
                    end else begin
                        q_n       = shreg;
                        q_valid_n = 1'b1;
                    end
                end else begin
                    frame_err_n  = 1'b1;
                    parity_err_n = par_bad;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath / output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            q          <= q_n;
            q_valid    <= q_valid_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_bad <= 1'b0;
        else     par_bad <= par_bad_n;
    end
`else
    assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: two instances (MSB_FIRST=1 and 0) share one serial
// line. Frames push their expected outcome onto a scoreboard, tagged with the
// cycle on which the strobe must appear; a negedge monitor pops and compares,
// and checks quiet cycles for stray strobes and q stability.

module tb_sipo_frame_rx;

    localparam int W = 4;

    typedef struct {
        int          cyc;
        logic        v;
        logic        fe;
        logic        pe;
        logic [W-1:0] w;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b1;
    logic [W-1:0] q0, q1;
    logic         qv0, fe0, pe0, qv1, fe1, pe1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t me;
    logic [W-1:0] mq = '0;

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .sin(sin), .q(q0),
        .q_valid(qv0), .frame_err(fe0), .parity_err(pe0)
    );

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .sin(sin), .q(q1),
        .q_valid(qv1), .frame_err(fe1), .parity_err(pe1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    // Monitor: sample mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            mq = '0;
            chk("rst_out", {q0, q1, qv0, fe0, pe0, qv1, fe1, pe1}, 0);
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            me = sb.pop_front();
            if (me.v) mq = me.w;
            chk("strobes", {qv0, fe0, pe0, qv1, fe1, pe1},
                {me.v, me.fe, me.pe, me.v, me.fe, me.pe});
            chk("q_msb", 32'(q0), 32'(mq));
            chk("q_lsb", 32'(q1), 32'(rev(mq)));
        end else begin
            chk("quiet", {qv0, fe0, pe0, qv1, fe1, pe1}, 0);
            chk("q_hold", {q0, q1}, {mq, rev(mq)});
        end
    end

    task automatic drive(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1);
    endtask

    // Send one frame; w is listed in transmission order (w[W-1] first).
    task automatic send(input logic [W-1:0] w, input logic stop, input logic par_ok);
        exp_t e;
        logic pok;
        drive(1'b0);
        for (int i = W - 1; i >= 0; i--) drive(w[i]);
`ifdef SIPO_PARITY_EN
        drive(par_ok ? ^w : ~(^w));
        pok = par_ok;
`else
        pok = 1'b1;
`endif
        drive(stop);
        e.cyc = cyc + 1;
        e.v   = stop && pok;
        e.fe  = !stop;
        e.pe  = !pok;
        e.w   = w;
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_q", {q0, q1}, 0);
        chk("reset_strb", {qv0, fe0, pe0, qv1, fe1, pe1}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        idle(20);

        // Basic frame and bit order
        send(4'b1101, 1'b1, 1'b1);
        idle(2);
        // Framing error: q keeps 1101
        send(4'b1010, 1'b0, 1'b1);
        idle(1);
        // Back-to-back frames
        send(4'b1101, 1'b1, 1'b1);
        send(4'b0010, 1'b1, 1'b1);

        // Reset during the 3rd data bit of a third frame
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", {q0, q1}, 0);
        chk("async_rst_strb", {qv0, fe0, pe0, qv1, fe1, pe1}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        sin = 1'b1;
        idle(2);
        send(4'b0110, 1'b1, 1'b1);
        idle(1);

        // Parity good, then parity bad (plain frame in the default build)
        send(4'b1101, 1'b1, 1'b1);
        send(4'b1101, 1'b1, 1'b0);
        send(4'b1001, 1'b0, 1'b0);

        // Random frames with random gaps
        for (int k = 0; k < 12; k++) begin
            send(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
